// File: rtl/pid_mc.sv
// Multi-channel PID controller. A single shared multiplier steps through the
// P, I and D products; each channel keeps its own previous sample and integrator.
module pid_mc #(
   parameter int WIDTH = 18,
   parameter int GW    = 12,
   parameter int FRAC  = 4,
   parameter int CH    = 4,
   parameter int CHW   = 2
) (
   input  logic                    sclk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CHW-1:0]          in_ch,
   input  logic signed [WIDTH-1:0] yk,
   input  logic signed [WIDTH-1:0] rk,
   input  logic signed [GW-1:0]    kp,
   input  logic signed [GW-1:0]    ki,
   input  logic signed [GW-1:0]    kd,
   input  logic [WIDTH-2:0]        sat_lim,
   output logic                    out_valid,
   output logic [CHW-1:0]          out_ch,
   output logic signed [WIDTH-1:0] pid_output,
   output logic                    sat_flag
);

   // state   | meaning
   // ST_IDLE | waiting for a sample; in_ready high while enabled
   // ST_P    | multiplier forms kp * -yk
   // ST_I    | multiplier forms ki * (rk - yk)
   // ST_D    | multiplier forms kd * -(yk - yk1[ch])
   // ST_SUM  | integrate, sum, clamp; results and channel state load on exit
   typedef enum logic [2:0] {ST_IDLE, ST_P, ST_I, ST_D, ST_SUM} state_t;

   localparam int PW = GW + WIDTH;
   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [PW-1:0]    PMAX = {{(GW+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0]    PMIN = ~PMAX;

   function automatic logic signed [WIDTH-1:0] sat_ext(input logic [WIDTH:0] v);
      if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? SMIN : SMAX;
      return v[WIDTH-1:0];
   endfunction

   function automatic logic signed [WIDTH-1:0] add_s(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
      return sat_ext({a[WIDTH-1], a} + {b[WIDTH-1], b});
   endfunction

   function automatic logic signed [WIDTH-1:0] sub_s(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
      return sat_ext({a[WIDTH-1], a} - {b[WIDTH-1], b});
   endfunction

   function automatic logic signed [WIDTH-1:0] neg_s(input logic signed [WIDTH-1:0] a);
      return sat_ext({(WIDTH+1){1'b0}} - {a[WIDTH-1], a});
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [PW-1:0] v);
      logic signed [PW-1:0] s;
      s = v >>> FRAC;
      if (s > PMAX) return SMAX;
      if (s < PMIN) return SMIN;
      return s[WIDTH-1:0];
   endfunction

   state_t state, state_nxt;
   logic   accept;

   logic [CHW-1:0]          ch_r;
   logic signed [WIDTH-1:0] yk_r, rk_r;
   logic signed [GW-1:0]    kp_r, ki_r, kd_r;
   logic [WIDTH-2:0]        lim_r;
   logic signed [WIDTH-1:0] p_r, kiek_r, d_r;

   logic signed [WIDTH-1:0] yk1 [CH];
   logic signed [WIDTH-1:0] ik1 [CH];
   logic signed [WIDTH-1:0] yk1_rd, ik1_rd;
   logic                    ch_ok;

   logic signed [GW-1:0]    mul_g;
   logic signed [WIDTH-1:0] mul_x;
   logic signed [PW-1:0]    prod;
   logic signed [WIDTH-1:0] mul_res;

   logic signed [WIDTH-1:0] ik_new, u, u_clamp, lim, nlim;
   logic                    clamped, windup;

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst)        state <= ST_IDLE;
      else if (enable) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_P;
         ST_P:    state_nxt = ST_I;
         ST_I:    state_nxt = ST_D;
         ST_D:    state_nxt = ST_SUM;
         ST_SUM:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == ST_IDLE) && enable;
      accept   = in_ready && in_valid;
      mul_g    = '0;
      mul_x    = '0;
      case (state)
         ST_P: begin
            mul_g = kp_r;
            mul_x = neg_s(yk_r);
         end
         ST_I: begin
            mul_g = ki_r;
            mul_x = sub_s(rk_r, yk_r);
         end
         ST_D: begin
            mul_g = kd_r;
            mul_x = neg_s(sub_s(yk_r, yk1_rd));
         end
         default: ;
      endcase
   end

   assign prod    = $signed({{WIDTH{mul_g[GW-1]}}, mul_g}) * $signed({{GW{mul_x[WIDTH-1]}}, mul_x});
   assign mul_res = sat_prod(prod);

   // Channel indices at or above CH have no storage; they read as zero and never write.
   always_comb begin
      yk1_rd = '0;
      ik1_rd = '0;
      ch_ok  = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (ch_r == CHW'(i)) begin
            yk1_rd = yk1[i];
            ik1_rd = ik1[i];
            ch_ok  = 1'b1;
         end
      end
   end

   always_comb begin
      ik_new  = add_s(ik1_rd, kiek_r);
      u       = add_s(add_s(ik_new, p_r), d_r);
      lim     = $signed({1'b0, lim_r});
      nlim    = neg_s(lim);
      u_clamp = u;
      clamped = 1'b0;
      if (u > lim) begin
         u_clamp = lim;
         clamped = 1'b1;
      end else if (u < nlim) begin
         u_clamp = nlim;
         clamped = 1'b1;
      end
      // Freeze the integrator only when it is pushing further into the clamp.
      windup = ((u > lim) && !kiek_r[WIDTH-1] && (kiek_r != '0)) ||
               ((u < nlim) && kiek_r[WIDTH-1]);
   end

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         ch_r   <= '0;
         yk_r   <= '0;
         rk_r   <= '0;
         kp_r   <= '0;
         ki_r   <= '0;
         kd_r   <= '0;
         lim_r  <= '0;
         p_r    <= '0;
         kiek_r <= '0;
         d_r    <= '0;
      end else if (enable) begin
         if (accept) begin
            ch_r  <= in_ch;
            yk_r  <= yk;
            rk_r  <= rk;
            kp_r  <= kp;
            ki_r  <= ki;
            kd_r  <= kd;
            lim_r <= sat_lim;
         end
         case (state)
            ST_P:    p_r    <= mul_res;
            ST_I:    kiek_r <= mul_res;
            ST_D:    d_r    <= mul_res;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         pid_output <= '0;
         sat_flag   <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            yk1[i] <= '0;
            ik1[i] <= '0;
         end
      end else if (enable) begin
         out_valid <= 1'b0;
         if ((state == ST_SUM) && ch_ok) begin
            out_valid  <= 1'b1;
            out_ch     <= ch_r;
            pid_output <= u_clamp;
            sat_flag   <= clamped;
            for (int i = 0; i < CH; i++) begin
               if (ch_r == CHW'(i)) begin
                  yk1[i] <= yk_r;
                  if (!windup) ik1[i] <= ik_new;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pid_mc.sv
// Self-checking bench for pid_mc: directed cases plus randomized samples
// checked against an arithmetic reference model of the PID rules.
module tb_pid_mc;

   logic               sclk = 1'b0;
   logic               rst, enable, in_valid;
   logic [1:0]         in_ch;
   logic signed [17:0] yk, rk;
   logic signed [11:0] kp, ki, kd;
   logic [16:0]        sat_lim;

   logic               in_ready, out_valid, sat_flag;
   logic [1:0]         out_ch;
   logic signed [17:0] pid_output;

   logic               in_ready3, out_valid3, sat_flag3;
   logic [1:0]         out_ch3;
   logic signed [17:0] pid_output3;

   int vectors = 0;
   int errors  = 0;
   longint m_yk1 [4];
   longint m_ik1 [4];

   pid_mc #(.WIDTH(18), .GW(12), .FRAC(4), .CH(4), .CHW(2)) dut (
      .sclk(sclk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .yk(yk), .rk(rk), .kp(kp), .ki(ki), .kd(kd), .sat_lim(sat_lim),
      .out_valid(out_valid), .out_ch(out_ch), .pid_output(pid_output), .sat_flag(sat_flag));

   pid_mc #(.WIDTH(18), .GW(12), .FRAC(4), .CH(3), .CHW(2)) dut3 (
      .sclk(sclk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready3),
      .in_ch(in_ch), .yk(yk), .rk(rk), .kp(kp), .ki(ki), .kd(kd), .sat_lim(sat_lim),
      .out_valid(out_valid3), .out_ch(out_ch3), .pid_output(pid_output3), .sat_flag(sat_flag3));

   always #5 sclk = ~sclk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout vectors=%0d miscompares=%0d", vectors, errors);
      $fatal(1);
   end

   function automatic longint sat18(input longint v);
      if (v > 131071)  return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_yk1[i] = 0;
         m_ik1[i] = 0;
      end
   endtask

   task automatic model(input int ch, input longint y, input longint r, input longint gp,
                        input longint gi, input longint gd, input longint lim,
                        output logic signed [17:0] e_pid, output logic e_flag);
      longint p, e, kiek, d, ikn, u, o;
      p    = sat18((gp * sat18(-y)) >>> 4);
      e    = sat18(r - y);
      kiek = sat18((gi * e) >>> 4);
      d    = sat18((gd * sat18(-sat18(y - m_yk1[ch]))) >>> 4);
      ikn  = sat18(m_ik1[ch] + kiek);
      u    = sat18(sat18(ikn + p) + d);
      o = u;
      e_flag = 1'b0;
      if (u > lim) begin
         o = lim;
         e_flag = 1'b1;
      end else if (u < -lim) begin
         o = -lim;
         e_flag = 1'b1;
      end
      if (!((u > lim && kiek > 0) || (u < -lim && kiek < 0))) m_ik1[ch] = ikn;
      m_yk1[ch] = y;
      e_pid = 18'(o);
   endtask

   task automatic drive(input logic [1:0] ch, input logic signed [17:0] y, input logic signed [17:0] r,
                        input logic signed [11:0] gp, input logic signed [11:0] gi,
                        input logic signed [11:0] gd, input logic [16:0] lim);
      in_ch = ch; yk = y; rk = r; kp = gp; ki = gi; kd = gd; sat_lim = lim;
   endtask

   task automatic scramble();
      in_ch = 2'($urandom); yk = 18'($urandom); rk = 18'($urandom);
      kp = 12'($urandom); ki = 12'($urandom); kd = 12'($urandom); sat_lim = 17'($urandom);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge sclk); #1;
         guard++;
      end
   endtask

   // Accepts one sample, scrambles inputs, reports edges-to-strobe and the strobed result.
   task automatic run_sample(input logic [1:0] ch, input logic signed [17:0] y, input logic signed [17:0] r,
                             input logic signed [11:0] gp, input logic signed [11:0] gi,
                             input logic signed [11:0] gd, input logic [16:0] lim,
                             output int lat, output logic signed [17:0] pid,
                             output logic flg, output logic [1:0] och);
      wait_ready();
      drive(ch, y, r, gp, gi, gd, lim);
      in_valid = 1'b1;
      @(posedge sclk); #1;
      in_valid = 1'b0;
      scramble();
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge sclk); #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      pid = pid_output;
      flg = sat_flag;
      och = out_ch;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; in_valid = 1'b0;
      drive(2'd0, 18'sd0, 18'sd0, 12'sd0, 12'sd0, 12'sd0, 17'd131071);
      model_clear();
      #23;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      vectors++; if (pid_output !== 18'sd0) begin errors++; $display("FAIL reset_pid got=%0d want=0", pid_output); end
      vectors++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got=%b want=0", sat_flag); end
      vectors++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got=%0d want=0", out_ch); end
      @(negedge sclk);
      rst = 1'b1;
      @(posedge sclk); #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_strobe got=%b want=0", out_valid); end
   endtask

   task automatic test_basic();
      int lat;
      logic signed [17:0] pid, ep;
      logic flg, ef;
      logic [1:0] och;
      model(0, 100, 300, 16, 8, 32, 131071, ep, ef);
      run_sample(2'd0, 18'sd100, 18'sd300, 12'sd16, 12'sd8, 12'sd32, 17'd131071, lat, pid, flg, och);
      vectors++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d want=4", lat); end
      vectors++; if (pid !== -18'sd200) begin errors++; $display("FAIL basic_pid got=%0d want=-200", pid); end
      vectors++; if (flg !== 1'b0) begin errors++; $display("FAIL basic_flag got=%b want=0", flg); end
      vectors++; if (och !== 2'd0) begin errors++; $display("FAIL basic_ch got=%0d want=0", och); end

      // Same sample again with in_valid held through the busy cycles.
      model(0, 100, 300, 16, 8, 32, 131071, ep, ef);
      drive(2'd0, 18'sd100, 18'sd300, 12'sd16, 12'sd8, 12'sd32, 17'd131071);
      in_valid = 1'b1;
      @(posedge sclk); #1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge sclk); #1;
         vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready k=%0d got=%b want=0", k, in_ready); end
      end
      @(posedge sclk); #1;
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL repeat_valid got=%b want=1", out_valid); end
      vectors++; if (pid_output !== 18'sd100) begin errors++; $display("FAIL repeat_pid got=%0d want=100", pid_output); end
      @(posedge sclk); #1;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL strobe_width got=%b want=0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL no_second_accept got=%b want=1", in_ready); end
      vectors++; if (pid_output !== 18'sd100) begin errors++; $display("FAIL pid_hold got=%0d want=100", pid_output); end

      model(1, 100, 300, 16, 8, 32, 131071, ep, ef);
      run_sample(2'd1, 18'sd100, 18'sd300, 12'sd16, 12'sd8, 12'sd32, 17'd131071, lat, pid, flg, och);
      vectors++; if (pid !== -18'sd200) begin errors++; $display("FAIL ch1_pid got=%0d want=-200", pid); end
      vectors++; if (och !== 2'd1) begin errors++; $display("FAIL ch1_ch got=%0d want=1", och); end

      model(0, 100, 300, 16, 8, 32, 131071, ep, ef);
      run_sample(2'd0, 18'sd100, 18'sd300, 12'sd16, 12'sd8, 12'sd32, 17'd131071, lat, pid, flg, och);
      vectors++; if (pid !== 18'sd200) begin errors++; $display("FAIL ch0_isolated got=%0d want=200", pid); end
   endtask

   task automatic test_windup();
      int lat;
      logic signed [17:0] pid, ep;
      logic flg, ef;
      logic [1:0] och;
      for (int n = 0; n < 3; n++) begin
         model(2, 0, 1000, 0, 16, 0, 50, ep, ef);
         run_sample(2'd2, 18'sd0, 18'sd1000, 12'sd0, 12'sd16, 12'sd0, 17'd50, lat, pid, flg, och);
         vectors++; if (pid !== 18'sd50) begin errors++; $display("FAIL windup_pid n=%0d got=%0d want=50", n, pid); end
         vectors++; if (flg !== 1'b1) begin errors++; $display("FAIL windup_flag n=%0d got=%b want=1", n, flg); end
      end
      model(2, 0, 0, 0, 16, 0, 50, ep, ef);
      run_sample(2'd2, 18'sd0, 18'sd0, 12'sd0, 12'sd16, 12'sd0, 17'd50, lat, pid, flg, och);
      vectors++; if (pid !== 18'sd0) begin errors++; $display("FAIL windup_release got=%0d want=0", pid); end
      vectors++; if (flg !== 1'b0) begin errors++; $display("FAIL windup_release_flag got=%b want=0", flg); end
   endtask

   task automatic test_enable_freeze();
      int lat = -1;
      logic signed [17:0] ep;
      logic ef;
      model(1, -1234, 777, 40, -20, 100, 131071, ep, ef);
      wait_ready();
      drive(2'd1, -18'sd1234, 18'sd777, 12'sd40, -12'sd20, 12'sd100, 17'd131071);
      in_valid = 1'b1;
      @(posedge sclk); #1;
      in_valid = 1'b0;
      scramble();
      for (int k = 1; k <= 12; k++) begin
         @(posedge sclk); #1;
         if (k == 1) enable = 1'b0;
         if (k == 4) enable = 1'b1;
         if (k >= 2 && k <= 3) begin
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL freeze_in_ready k=%0d got=%b want=0", k, in_ready); end
         end
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      vectors++; if (lat !== 7) begin errors++; $display("FAIL freeze_latency got=%0d want=7", lat); end
      vectors++; if (pid_output !== ep) begin errors++; $display("FAIL freeze_pid got=%0d want=%0d", pid_output, ep); end
      vectors++; if (sat_flag !== ef) begin errors++; $display("FAIL freeze_flag got=%b want=%b", sat_flag, ef); end
   endtask

   task automatic test_reset_inflight();
      logic saw = 1'b0;
      wait_ready();
      drive(2'd3, 18'sd500, -18'sd500, 12'sd100, 12'sd100, 12'sd100, 17'd131071);
      in_valid = 1'b1;
      @(posedge sclk); #1;
      in_valid = 1'b0;
      @(posedge sclk); #1;
      rst = 1'b0;
      model_clear();
      #1;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_valid got=%b want=0", out_valid); end
      vectors++; if (pid_output !== 18'sd0) begin errors++; $display("FAIL rst_inflight_pid got=%0d want=0", pid_output); end
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_inflight_ready got=%b want=1", in_ready); end
      for (int k = 0; k < 6; k++) begin
         @(posedge sclk); #1;
         if (out_valid) saw = 1'b1;
      end
      vectors++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_inflight_strobe got=%b want=0", saw); end
   endtask

   task automatic test_ch3();
      logic signed [17:0] ep, hold3;
      logic ef, saw3 = 1'b0;
      model(3, 2000, -3000, 64, 32, -16, 131071, ep, ef);
      wait_ready();
      hold3 = pid_output3;
      drive(2'd3, 18'sd2000, -18'sd3000, 12'sd64, 12'sd32, -12'sd16, 17'd131071);
      in_valid = 1'b1;
      @(posedge sclk); #1;
      in_valid = 1'b0;
      scramble();
      for (int k = 1; k <= 4; k++) begin
         @(posedge sclk); #1;
         if (out_valid3) saw3 = 1'b1;
         if (k == 3) begin
            vectors++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL ch3_busy got=%b want=0", in_ready3); end
         end
      end
      vectors++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL ch3_ready_return got=%b want=1", in_ready3); end
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ch3_valid got=%b want=1", out_valid); end
      vectors++; if (out_ch !== 2'd3) begin errors++; $display("FAIL ch3_out_ch got=%0d want=3", out_ch); end
      vectors++; if (pid_output !== ep) begin errors++; $display("FAIL ch3_pid got=%0d want=%0d", pid_output, ep); end
      @(posedge sclk); #1;
      if (out_valid3) saw3 = 1'b1;
      vectors++; if (saw3 !== 1'b0) begin errors++; $display("FAIL ch3_oob_strobe got=%b want=0", saw3); end
      vectors++; if (pid_output3 !== hold3) begin errors++; $display("FAIL ch3_oob_hold got=%0d want=%0d", pid_output3, hold3); end
   endtask

   task automatic test_random();
      int lat, ch;
      logic signed [17:0] y, r, pid, ep;
      logic signed [11:0] gp, gi, gd;
      logic [16:0] lim;
      logic flg, ef;
      logic [1:0] och;
      for (int n = 0; n < 40; n++) begin
         ch = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            y = 18'(int'($urandom_range(0, 4000)) - 2000);
            r = 18'(int'($urandom_range(0, 4000)) - 2000);
         end else begin
            y = 18'($urandom);
            r = 18'($urandom);
         end
         gp = 12'($urandom); gi = 12'($urandom); gd = 12'($urandom);
         lim = ($urandom_range(0, 2) == 0) ? 17'($urandom_range(0, 3000)) : 17'($urandom);
         model(ch, y, r, gp, gi, gd, lim, ep, ef);
         run_sample(2'(ch), y, r, gp, gi, gd, lim, lat, pid, flg, och);
         vectors++; if (lat !== 4) begin errors++; $display("FAIL rand_latency n=%0d got=%0d want=4", n, lat); end
         vectors++; if (pid !== ep) begin errors++; $display("FAIL rand_pid n=%0d got=%0d want=%0d", n, pid, ep); end
         vectors++; if (flg !== ef) begin errors++; $display("FAIL rand_flag n=%0d got=%b want=%b", n, flg, ef); end
         vectors++; if (och !== 2'(ch)) begin errors++; $display("FAIL rand_ch n=%0d got=%0d want=%0d", n, och, ch); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_windup();
      test_enable_freeze();
      test_reset_inflight();
      test_ch3();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pid_mc.md
PID_MC -- requirements
Module: pid_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 18: signed width of all samples, states and the output.
REQ-002 SHALL provide parameter GW, default 12: signed width of each gain port.
REQ-003 SHALL provide parameter FRAC, default 4: fractional bits of the gains.
REQ-004 SHALL provide parameter CH, default 4: number of channels, 1 <= CH <= 2^CHW.
REQ-005 SHALL provide parameter CHW, default 2: width of the channel index.
REQ-006 Port sclk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous reset, active-low.
REQ-008 Port enable, input, 1 bit: high = run; low = freeze all state.
REQ-009 Port in_valid, input, 1 bit: sample request.
REQ-010 Port in_ready, output, 1 bit: block can accept a sample.
REQ-011 Port in_ch, input, CHW bits: channel of the sample.
REQ-012 Ports yk and rk, input, signed WIDTH each: measurement and reference.
REQ-013 Ports kp, ki and kd, input, signed GW each: gains, scaled by 2^-FRAC.
REQ-014 Port sat_lim, input, unsigned WIDTH-1 bits: symmetric output clamp limit.
REQ-015 Port out_valid, output, 1 bit: one-cycle result strobe.
REQ-016 Port out_ch, output, CHW bits: channel of the result.
REQ-017 Port pid_output, output, signed WIDTH: controller output.
REQ-018 Port sat_flag, output, 1 bit: the result was clamped.

Function
REQ-019 SHALL sample in_ch, yk, rk, kp, ki, kd and sat_lim on a rising edge where in_valid, in_ready and enable are all high ("accept").
REQ-020 FSM SHALL have states IDLE, P, I, D, SUM, with transitions IDLE->P on accept, then P->I->D->SUM->IDLE, one edge per step.
REQ-021 in_ready SHALL be 1 only in IDLE with enable high; in_valid in any other state SHALL be ignored.
REQ-022 A single shared GW x WIDTH multiplier SHALL be used; each product is arithmetic-shifted right by FRAC, then saturated to signed WIDTH.
REQ-023 State P SHALL compute p = sat(kp * -yk).
REQ-024 State I SHALL compute kiek = sat(ki * ek), where ek = sat(rk - yk).
REQ-025 State D SHALL compute d = sat(kd * -sat(yk - yk1[ch])).
REQ-026 State SUM SHALL compute ik_new = sat(ik1[ch] + kiek) and u = sat(ik_new + p + d), with each addition performed at WIDTH+1 bits and saturated.
REQ-027 The output SHALL be pid_output = u clamped to [-sat_lim, +sat_lim]; sat_flag = 1 if clamping occurred.
REQ-028 Anti-windup: if u > sat_lim with kiek > 0, or u < -sat_lim with kiek < 0, ik1[ch] SHALL keep its old value; otherwise ik1[ch] <= ik_new.
REQ-029 On the SUM->IDLE edge, yk1[ch] SHALL be written with yk.
REQ-030 On the same SUM->IDLE edge, pid_output, sat_flag and out_ch SHALL load and out_valid SHALL be 1 for exactly the following cycle.
REQ-031 Latency: out_valid SHALL be high in the cycle after the 4th edge following accept; throughput is one sample per 5 cycles.
REQ-032 Each channel SHALL hold its own yk1/ik1 pair; a sample on one channel SHALL NOT alter any other channel's state.
REQ-033 A sample with in_ch >= CH SHALL be accepted and run through the FSM, with no state write and no out_valid pulse.
REQ-034 With enable low, FSM, datapath registers, channel state, out_valid and the outputs SHALL hold their values.
REQ-035 pid_output, sat_flag and out_ch SHALL hold their values between strobes.

Reset
REQ-036 While rst = 0, the block SHALL immediately enter state IDLE, set out_valid, sat_flag, out_ch and pid_output to 0, and set every yk1 and ik1 to 0.
REQ-037 An in-flight sample interrupted by reset SHALL be discarded; in_ready SHALL be 1 in the first enabled cycle after rst rises.

Verification (WIDTH=18, GW=12, FRAC=4, CH=4, sat_lim=131071 unless stated)
REQ-038 Reset: rst low, then release with enable=1 -> all outputs 0 and in_ready=1.
REQ-039 ch0, yk=100, rk=300, kp=16, ki=8, kd=32 -> 5 cycles later out_valid=1, out_ch=0, pid_output=-200, sat_flag=0; then in_valid held high during the busy cycles -> no second accept.
REQ-040 Repeat the REQ-039 sample on ch0 -> pid_output=100. Then a ch1 sample with the same values -> pid_output=-200, and ch0 state is unchanged.
REQ-041 Windup: kp=0, kd=0, ki=16, yk=0, rk=1000, sat_lim=50, three samples -> pid_output=50 and sat_flag=1 each time; then rk=0 -> pid_output=0 (integrator stayed 0).
REQ-042 Reset, or enable low, asserted during state I -> on reset, out_valid=0 immediately and no strobe; on enable low for 3 cycles, the result is delayed by exactly 3 cycles and its value is unchanged.
REQ-043 Sample with in_ch=3 exercises the highest channel; with CH=3, in_ch=3 -> no out_valid, and in_ready returns 5 cycles after accept.
